// File: rtl/quantum_sequencer.sv
// quantum_sequencer: dispatches PULSE ops into per-channel FIFOs and sequences DELAY/WAIT ops.
// Latency: an accepted PULSE appears on pulse_valid one cycle later; DELAY N stalls exactly N cycles.
// Backpressure: q_stall holds execute while a target FIFO is full or while in DELAY/WAIT; pulse_ready pops per channel.
// Optional feature macro: QSEQ_TIMESTAMP_EN (free-running 32-bit timestamp stored with each descriptor).

// Generic synchronous FIFO: power-of-two depth, registered occupancy, storage cleared on reset.
// Latency: a push is visible on o_dat one cycle later; o_dat shows the head entry combinationally.
// Backpressure: pushes while full and pops while empty are ignored; o_full/o_empty are registered.
module qseq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd_ptr];

  // Storage write and pointer/occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module quantum_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int DESC_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int DELAY_W    = 12
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       q_valid,
  input  logic [1:0]                                 q_op,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] q_ch,
  input  logic [DESC_W-1:0]                          q_desc,
  input  logic [DELAY_W-1:0]                         q_delay,
  output logic                                       q_stall,
  output logic [NUM_CH-1:0]                          pulse_valid,
  input  logic [NUM_CH-1:0]                          pulse_ready,
  output logic [NUM_CH*DESC_W-1:0]                   pulse_desc,
  output logic [NUM_CH*32-1:0]                       pulse_ts,
  input  logic [NUM_CH-1:0]                          ext_empty,
  output logic                                       busy,
  output logic                                       ch_err
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] OP_PULSE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DELAY_W-1:0] r_cnt;
  logic [DELAY_W-1:0] w_cnt_nxt;
  logic               w_acc;
  logic               w_ch_ok;
  logic               w_sel_full;
  logic [NUM_CH-1:0]  w_push;
  logic [NUM_CH-1:0]  w_pop;
  logic [NUM_CH-1:0]  w_full;
  logic [NUM_CH-1:0]  w_empty;

`ifdef QSEQ_TIMESTAMP_EN
  localparam int FW = DESC_W + 32;
  logic [31:0] r_ts_cnt;
  logic [FW-1:0] w_push_dat;

  // Free-running cycle counter; wraps through zero after 2^32-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
    end
  end

  assign w_push_dat = {r_ts_cnt, q_desc};
`else
  localparam int FW = DESC_W;
  logic [FW-1:0] w_push_dat;

  assign w_push_dat = q_desc;
`endif

  logic [FW-1:0] w_fifo_dat [NUM_CH];

  // Decode target channel: validity and fullness of the addressed FIFO (out-of-range q_ch selects nothing).
  always_comb begin
    w_ch_ok    = 1'b0;
    w_sel_full = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (q_ch == CH_W'(c)) begin
        w_ch_ok    = 1'b1;
        w_sel_full = w_full[c];
      end
    end
  end

  // Stall on registered fullness only, so a pop in the same cycle never lets a push through.
  assign q_stall = (r_state != S_IDLE) ||
                   (q_valid && (q_op == OP_PULSE) && w_ch_ok && w_sel_full);
  assign w_acc   = q_valid && !q_stall;
  assign busy    = (r_state != S_IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_push[c]      = w_acc && (q_op == OP_PULSE) && (q_ch == CH_W'(c));
    assign w_pop[c]       = pulse_valid[c] && pulse_ready[c];
    assign pulse_valid[c] = !w_empty[c];
    assign pulse_desc[c*DESC_W +: DESC_W] = w_fifo_dat[c][DESC_W-1:0];
`ifdef QSEQ_TIMESTAMP_EN
    assign pulse_ts[c*32 +: 32] = w_fifo_dat[c][FW-1 -: 32];
`endif

    qseq_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push[c]),
      .i_dat   (w_push_dat),
      .i_pop   (w_pop[c]),
      .o_dat   (w_fifo_dat[c]),
      .o_full  (w_full[c]),
      .o_empty (w_empty[c])
    );
  end

`ifndef QSEQ_TIMESTAMP_EN
  assign pulse_ts = '0;
`endif

  // Sticky error: an accepted PULSE addressed to a channel that does not exist.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_err <= 1'b0;
    end else if (w_acc && (q_op == OP_PULSE) && !w_ch_ok) begin
      ch_err <= 1'b1;
    end
  end

  // State and delay counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: DELAY counts N cycles down to 1, WAIT exits once every FIFO inside and out is empty.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_acc && (q_op == OP_DELAY) && (q_delay != '0)) begin
          w_state_nxt = S_DELAY;
          w_cnt_nxt   = q_delay;
        end else if (w_acc && (q_op == OP_WAIT)) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DELAY: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == DELAY_W'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if ((&w_empty) && (&ext_empty)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_quantum_sequencer.sv
// Directed bench with a descriptor scoreboard: issued PULSEs queue their expected descriptor/timestamp,
// and a monitor pops and compares whenever a channel handshakes.
module tb_quantum_sequencer;
  localparam int NUM_CH  = 4;
  localparam int DESC_W  = 64;
  localparam int DELAY_W = 12;

  localparam logic [1:0] OP_PULSE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       q_valid;
  logic [1:0]                 q_op;
  logic [1:0]                 q_ch;
  logic [DESC_W-1:0]          q_desc;
  logic [DELAY_W-1:0]         q_delay;
  logic                       q_stall;
  logic [NUM_CH-1:0]          pulse_valid;
  logic [NUM_CH-1:0]          pulse_ready;
  logic [NUM_CH*DESC_W-1:0]   pulse_desc;
  logic [NUM_CH*32-1:0]       pulse_ts;
  logic [NUM_CH-1:0]          ext_empty;
  logic                       busy;
  logic                       ch_err;

  quantum_sequencer #(
    .NUM_CH     (NUM_CH),
    .DESC_W     (DESC_W),
    .FIFO_DEPTH (4),
    .DELAY_W    (DELAY_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .q_valid     (q_valid),
    .q_op        (q_op),
    .q_ch        (q_ch),
    .q_desc      (q_desc),
    .q_delay     (q_delay),
    .q_stall     (q_stall),
    .pulse_valid (pulse_valid),
    .pulse_ready (pulse_ready),
    .pulse_desc  (pulse_desc),
    .pulse_ts    (pulse_ts),
    .ext_empty   (ext_empty),
    .busy        (busy),
    .ch_err      (ch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [63:0] desc;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb_q[$];
  int          errs = 0;
  int          chks = 0;
  logic [31:0] tb_cyc;

  // Reference cycle count, reset and advanced exactly like a free-running timestamp.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present an op and hold it until accepted; reports how many cycles it was stalled.
  task automatic issue(input logic [1:0] op, input logic [1:0] ch, input logic [63:0] desc,
                       input logic [11:0] dly, output int stalls);
    logic [31:0] ets;
    stalls  = 0;
    q_valid = 1'b1;
    q_op    = op;
    q_ch    = ch;
    q_desc  = desc;
    q_delay = dly;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!q_stall) begin
`ifdef QSEQ_TIMESTAMP_EN
        ets = tb_cyc;
`else
        ets = '0;
`endif
        if (op == OP_PULSE) sb_q.push_back('{int'(ch), desc, ets});
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        return;
      end
      stalls++;
    end
    chks++;
    errs++;
    $display("FAIL accept_timeout: got %0d stall cycles expected acceptance", stalls);
    q_valid = 1'b0;
  endtask

  // Monitor: every handshake must match the oldest outstanding descriptor for that channel.
  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pulse_valid[c] && pulse_ready[c]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb_q.size(); i++) begin
            if (idx < 0 && sb_q[i].ch == c) idx = i;
          end
          if (idx < 0) begin
            chks++;
            errs++;
            $display("FAIL unexpected_pulse_ch%0d: got %0h expected no pulse", c, pulse_desc[c*DESC_W +: DESC_W]);
          end else begin
            check($sformatf("desc_ch%0d", c), pulse_desc[c*DESC_W +: DESC_W], sb_q[idx].desc);
            check($sformatf("ts_ch%0d", c), {32'b0, pulse_ts[c*32 +: 32]}, {32'b0, sb_q[idx].ts});
            sb_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    reset       = 1'b0;
    q_valid     = 1'b0;
    q_op        = OP_NOP;
    q_ch        = '0;
    q_desc      = '0;
    q_delay     = '0;
    pulse_ready = '1;
    ext_empty   = '1;

    // Reset state
    #12;
    check("rst_stall", q_stall, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", pulse_valid, 0);
    check("rst_ch_err", ch_err, 0);
    @(negedge clk);
    reset = 1'b1;
    step(2);

    // Single pulse to ch2 with downstream ready: valid next cycle, popped that cycle
    issue(OP_PULSE, 2'd2, 64'hA5, 12'd0, st);
    check("pulse_ch2_stalls", st, 0);
    check("pulse_ch2_valid", pulse_valid, 4'b0100);
    step(1);
    check("pulse_ch2_popped", pulse_valid, 4'b0000);

    // NOP: accepted, no effect
    issue(OP_NOP, 2'd1, 64'hFF, 12'd5, st);
    check("nop_stalls", st, 0);
    check("nop_busy", busy, 0);
    check("nop_valid", pulse_valid, 4'b0000);

    // Fill ch0 (depth 4) with its consumer blocked
    pulse_ready = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      issue(OP_PULSE, 2'd0, 64'h10 + 64'(i), 12'd0, st);
      check($sformatf("fill%0d_stalls", i), st, 0);
    end
    check("ch0_full_valid", pulse_valid, 4'b0001);
    issue(OP_NOP, 2'd0, 64'h0, 12'd0, st);
    check("nop_on_full_stalls", st, 0);
    q_valid = 1'b1;
    q_op    = OP_PULSE;
    q_ch    = 2'd0;
    q_desc  = 64'h14;
    @(negedge clk);
    check("fifth_stalled", q_stall, 1);
    step(2);
    check("fifth_still_stalled", q_stall, 1);
    pulse_ready = 4'b1111;
    #1;
    check("same_cycle_pop_no_relief", q_stall, 1);
    issue(OP_PULSE, 2'd0, 64'h14, 12'd0, st);
    check("fifth_accept_after_pop", st, 1);
    step(6);
    check("ch0_drained", pulse_valid, 4'b0000);

    // DELAY 3 with a ch3 entry draining during the delay
    pulse_ready = 4'b0111;
    issue(OP_PULSE, 2'd3, 64'h33, 12'd0, st);
    issue(OP_DELAY, 2'd0, 64'h0, 12'd3, st);
    check("delay3_accept_stalls", st, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("delay3_stall_t%0d", i + 1), q_stall, (i < 3));
      check($sformatf("delay3_busy_t%0d", i + 1), busy, (i < 3));
      if (i == 0) pulse_ready = 4'b1111;
      step(1);
    end
    check("drain_in_delay", pulse_valid, 4'b0000);
    issue(OP_DELAY, 2'd0, 64'h0, 12'd0, st);
    check("delay0_stalls", st, 0);
    check("delay0_stall_after", q_stall, 0);
    check("delay0_busy", busy, 0);

    // WAIT with two ch1 entries and ch1 downstream not empty
    pulse_ready = 4'b1101;
    ext_empty   = 4'b1101;
    issue(OP_PULSE, 2'd1, 64'h21, 12'd0, st);
    issue(OP_PULSE, 2'd1, 64'h22, 12'd0, st);
    issue(OP_WAIT, 2'd0, 64'h0, 12'd0, st);
    check("wait_accept_stalls", st, 0);
    step(2);
    check("wait_stall", q_stall, 1);
    check("wait_busy", busy, 1);
    pulse_ready = 4'b1111;
    step(2);
    check("wait_fifo_drained", pulse_valid, 4'b0000);
    check("wait_hold_ext", q_stall, 1);
    step(2);
    check("wait_hold_ext_later", q_stall, 1);
    ext_empty = 4'b1111;
    #1;
    check("wait_release_next_cycle", q_stall, 1);
    step(1);
    check("wait_released", q_stall, 0);
    check("wait_idle", busy, 0);

    // Reset mid-DELAY with a pending ch3 entry
    pulse_ready = 4'b0111;
    issue(OP_PULSE, 2'd3, 64'h3C, 12'd0, st);
    issue(OP_DELAY, 2'd0, 64'h0, 12'd8, st);
    step(3);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_valid", pulse_valid, 4'b1000);
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_stall", q_stall, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", pulse_valid, 4'b0000);
    check("midrst_desc_zero", (pulse_desc == '0), 1);
    check("midrst_ts_zero", (pulse_ts == '0), 1);
    @(negedge clk);
    reset       = 1'b1;
    pulse_ready = 4'b1111;
    step(9);
    check("post_rst_idle", busy, 0);

    // Post-reset pulse: timestamp (when enabled) follows the restarted counter
    issue(OP_PULSE, 2'd0, 64'h77, 12'd0, st);
    check("post_rst_pulse_stalls", st, 0);
    check("post_rst_valid", pulse_valid, 4'b0001);

    step(5);
    check("scoreboard_empty", sb_q.size(), 0);
    check("ch_err_clear", ch_err, 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
